// File: rtl/iecdrv_pkg.sv
// Shared types and helpers for the drive-to-host SD arbiter.
// Imported by the picker and the arbiter top.
package iecdrv_pkg;

  localparam int MAXDRV = 4;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    XFER
  } state_e;

  typedef enum logic {
    READ,
    WRITE
  } op_e;

  function automatic int clamp_ndr(input int d);
    if (d < 1) return 1;
    else if (d > MAXDRV) return MAXDRV;
    else return d;
  endfunction

endpackage

// File: rtl/iecdrv_rr_pick.sv
// Round-robin picker: first set request scanning from ptr, wrapping at ndr.
// Purely combinational.
module iecdrv_rr_pick
  import iecdrv_pkg::*;
(
  input  logic [MAXDRV-1:0] req_i,
  input  logic [1:0]        ptr_i,
  input  logic [2:0]        ndr_i,
  output logic              valid_o,
  output logic [1:0]        idx_o
);

  logic [2:0] sum;

  // Scan from the far end so the closest candidate is written last.
  always_comb begin
    valid_o = 1'b0;
    idx_o   = '0;
    sum     = '0;
    for (int k = MAXDRV - 1; k >= 0; k--) begin
      sum = {1'b0, ptr_i} + 3'(k);
      if (sum >= ndr_i) sum = sum - ndr_i;
      if ((3'(k) < ndr_i) && req_i[sum[1:0]]) begin
        valid_o = 1'b1;
        idx_o   = sum[1:0];
      end
    end
  end

endmodule

// File: rtl/iecdrv_sd_arb.sv
// Multiplexes up to four drive SD sector requests onto one host SD port,
// with round-robin fairness, ack timeout and per-drive reset withdrawal.
module iecdrv_sd_arb
  import iecdrv_pkg::*;
#(
  parameter int          DRIVES      = 2,
  parameter logic [23:0] TIMEOUT_CYC = 24'd16000000
) (
  input  logic                                 clk_sys,
  input  logic                                 reset_n,
  input  logic [clamp_ndr(DRIVES)-1:0]         drv_reset,
  input  logic [clamp_ndr(DRIVES)-1:0][31:0]   drv_lba,
  input  logic [clamp_ndr(DRIVES)-1:0][5:0]    drv_blk_cnt,
  input  logic [clamp_ndr(DRIVES)-1:0]         drv_rd,
  input  logic [clamp_ndr(DRIVES)-1:0]         drv_wr,
  input  logic [clamp_ndr(DRIVES)-1:0][7:0]    drv_buff_din,
  output logic [clamp_ndr(DRIVES)-1:0]         drv_ack,
  output logic [clamp_ndr(DRIVES)-1:0]         drv_err,
  output logic [31:0]                          sd_lba,
  output logic [5:0]                           sd_blk_cnt,
  output logic                                 sd_rd,
  output logic                                 sd_wr,
  input  logic                                 sd_ack,
  output logic [7:0]                           sd_buff_din,
  output logic                                 busy,
  output logic [1:0]                           grant
);

  localparam int         NDR  = clamp_ndr(DRIVES);
  localparam logic [2:0] NDR3 = 3'(NDR);

  state_e          state_q, state_d;
  op_e             op_q, op_d;
  logic [1:0]      rr_q, rr_d;
  logic [1:0]      grant_q, grant_d;
  logic            stb_q, stb_d;
  logic [23:0]     cnt_q, cnt_d;
  logic [31:0]     lba_q, lba_d;
  logic [5:0]      blk_q, blk_d;
  logic [NDR-1:0]  err_q, err_d;

  logic [MAXDRV-1:0]       req_w, rd_w;
  logic [MAXDRV-1:0][31:0] lba_w;
  logic [MAXDRV-1:0][5:0]  blk_w;
  logic [MAXDRV-1:0][7:0]  din_w;
  logic                    pick_vld;
  logic [1:0]              pick_idx;
  logic [1:0]              nxt_w;
  logic                    tmo_hit;

  // Pad the per-drive vectors to MAXDRV so 2-bit indices are always legal.
  always_comb begin
    req_w = '0;
    rd_w  = '0;
    lba_w = '0;
    blk_w = '0;
    din_w = '0;
    for (int i = 0; i < NDR; i++) begin
      req_w[i] = (drv_rd[i] | drv_wr[i]) & ~drv_reset[i];
      rd_w[i]  = drv_rd[i];
      lba_w[i] = drv_lba[i];
      blk_w[i] = drv_blk_cnt[i];
      din_w[i] = drv_buff_din[i];
    end
  end

  iecdrv_rr_pick u_pick (
    .req_i   (req_w),
    .ptr_i   (rr_q),
    .ndr_i   (NDR3),
    .valid_o (pick_vld),
    .idx_o   (pick_idx)
  );

  assign nxt_w = (({1'b0, grant_q} + 3'd1) >= NDR3) ? 2'd0
               : grant_q + 2'd1;

  assign tmo_hit = (TIMEOUT_CYC != 24'd0)
                && (cnt_q == TIMEOUT_CYC - 24'd1);

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    rr_d    = rr_q;
    grant_d = grant_q;
    stb_d   = stb_q;
    cnt_d   = cnt_q;
    lba_d   = lba_q;
    blk_d   = blk_q;
    err_d   = '0;
    unique case (state_q)
      IDLE: begin
        if (pick_vld) begin
          grant_d = pick_idx;
          lba_d   = lba_w[pick_idx];
          blk_d   = blk_w[pick_idx];
          op_d    = rd_w[pick_idx] ? READ : WRITE;
          stb_d   = 1'b1;
          cnt_d   = '0;
          state_d = REQ;
        end
      end
      REQ: begin
        if (sd_ack) begin
          stb_d   = 1'b0;
          state_d = XFER;
        end else if (!req_w[grant_q]) begin
          stb_d   = 1'b0;
          state_d = IDLE;
        end else if (tmo_hit) begin
          stb_d   = 1'b0;
          rr_d    = nxt_w;
          state_d = IDLE;
          for (int i = 0; i < NDR; i++) begin
            if (grant_q == 2'(i)) err_d[i] = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 24'd1;
        end
      end
      XFER: begin
        if (!sd_ack) begin
          rr_d    = nxt_w;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      state_q <= IDLE;
      op_q    <= READ;
      rr_q    <= '0;
      grant_q <= '0;
      stb_q   <= 1'b0;
      cnt_q   <= '0;
      lba_q   <= '0;
      blk_q   <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      rr_q    <= rr_d;
      grant_q <= grant_d;
      stb_q   <= stb_d;
      cnt_q   <= cnt_d;
      lba_q   <= lba_d;
      blk_q   <= blk_d;
      err_q   <= err_d;
    end
  end

  assign busy        = (state_q != IDLE);
  assign grant       = grant_q;
  assign sd_rd       = stb_q & (op_q == READ);
  assign sd_wr       = stb_q & (op_q == WRITE);
  assign sd_lba      = lba_q;
  assign sd_blk_cnt  = blk_q;
  assign drv_err     = err_q;
  assign sd_buff_din = busy ? din_w[grant_q] : 8'hFF;

  always_comb begin
    drv_ack = '0;
    for (int i = 0; i < NDR; i++) begin
      drv_ack[i] = sd_ack & busy & (grant_q == 2'(i)) & ~drv_reset[i];
    end
  end

endmodule

// File: tb/tb_iecdrv_sd_arb.sv
// Bench for iecdrv_sd_arb: directed scenarios then random drives and host,
// compared every cycle against a transaction-level model.
module tb_iecdrv_sd_arb;

  localparam int NDR = 4;
  localparam int TMO = 10;

  logic             clk_sys = 1'b0;
  logic             reset_n;
  logic [3:0]       drv_reset, drv_rd, drv_wr;
  logic [3:0]       drv_ack, drv_err;
  logic [3:0][31:0] drv_lba;
  logic [3:0][5:0]  drv_blk_cnt;
  logic [3:0][7:0]  drv_buff_din;
  logic [31:0]      sd_lba;
  logic [5:0]       sd_blk_cnt;
  logic             sd_rd, sd_wr, sd_ack;
  logic [7:0]       sd_buff_din;
  logic             busy;
  logic [1:0]       grant;

  always #5 clk_sys = ~clk_sys;

  iecdrv_sd_arb #(
    .DRIVES      (NDR),
    .TIMEOUT_CYC (24'(TMO))
  ) dut (
    .clk_sys      (clk_sys),
    .reset_n      (reset_n),
    .drv_reset    (drv_reset),
    .drv_lba      (drv_lba),
    .drv_blk_cnt  (drv_blk_cnt),
    .drv_rd       (drv_rd),
    .drv_wr       (drv_wr),
    .drv_buff_din (drv_buff_din),
    .drv_ack      (drv_ack),
    .drv_err      (drv_err),
    .sd_lba       (sd_lba),
    .sd_blk_cnt   (sd_blk_cnt),
    .sd_rd        (sd_rd),
    .sd_wr        (sd_wr),
    .sd_ack       (sd_ack),
    .sd_buff_din  (sd_buff_din),
    .busy         (busy),
    .grant        (grant)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Model: current owner (-1 = none), whether the host accepted, wait age.
  int          m_own = -1;
  int          m_grant, m_age, m_ptr;
  bit          m_xfer, m_rd;
  logic [31:0] m_lba;
  logic [5:0]  m_blk;
  logic [3:0]  m_err;
  logic [3:0]  e_ack;
  int          h_cnt;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_own = -1; m_grant = 0; m_age = 0; m_ptr = 0;
    m_xfer = 0; m_rd = 0; m_lba = '0; m_blk = '0; m_err = '0;
  endtask

  task automatic model_update();
    logic [3:0] req;
    bit found;
    int j;
    req   = (drv_rd | drv_wr) & ~drv_reset;
    m_err = '0;
    if (!reset_n) begin
      model_reset();
    end else if (m_own < 0) begin
      found = 0;
      for (int k = 0; k < NDR; k++) begin
        j = (m_ptr + k) % NDR;
        if (!found && req[j]) begin found = 1; m_own = j; end
      end
      if (found) begin
        m_grant = m_own; m_xfer = 0; m_age = 0;
        m_rd  = drv_rd[m_own];
        m_lba = drv_lba[m_own];
        m_blk = drv_blk_cnt[m_own];
      end
    end else if (!m_xfer) begin
      if (sd_ack) m_xfer = 1;
      else if (!req[m_own]) m_own = -1;
      else if (m_age == TMO - 1) begin
        m_err[m_own] = 1'b1;
        m_ptr = (m_own + 1) % NDR;
        m_own = -1;
      end else m_age++;
    end else if (!sd_ack) begin
      m_ptr = (m_own + 1) % NDR;
      m_own = -1;
    end
  endtask

  task automatic check_outputs();
    bit b, stb;
    b   = (m_own >= 0);
    stb = b && !m_xfer;
    for (int i = 0; i < NDR; i++)
      e_ack[i] = sd_ack && b && (m_grant == i) && !drv_reset[i];
    chk("busy", busy, b);
    chk("grant", grant, m_grant[1:0]);
    chk("sd_rd", sd_rd, stb && m_rd);
    chk("sd_wr", sd_wr, stb && !m_rd);
    chk("sd_lba", sd_lba, m_lba);
    chk("sd_blk_cnt", sd_blk_cnt, m_blk);
    chk("drv_err", drv_err, m_err);
    chk("drv_ack", drv_ack, e_ack);
    chk("sd_buff_din", sd_buff_din,
        b ? drv_buff_din[m_grant] : 8'hFF);
  endtask

  task automatic step();
    #1;
    check_outputs();
    @(posedge clk_sys);
    model_update();
    @(negedge clk_sys);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic rand_inputs();
    int v;
    bit stb;
    for (int i = 0; i < NDR; i++) begin
      drv_lba[i]      = $urandom;
      drv_blk_cnt[i]  = 6'($urandom);
      drv_buff_din[i] = 8'($urandom);
      drv_reset[i]    = ($urandom_range(0, 39) == 0);
      if (drv_rd[i] | drv_wr[i]) begin
        if (e_ack[i]) begin
          if (drv_rd[i] && drv_wr[i] && $urandom_range(0, 1) == 1)
            drv_rd[i] = 1'b0;
          else if ($urandom_range(0, 3) != 0) begin
            drv_rd[i] = 1'b0; drv_wr[i] = 1'b0;
          end
        end else if ($urandom_range(0, 63) == 0) begin
          drv_rd[i] = 1'b0; drv_wr[i] = 1'b0;
        end
      end else if ($urandom_range(0, 7) == 0) begin
        v = $urandom_range(1, 3);
        drv_rd[i] = v[0];
        drv_wr[i] = v[1];
      end
    end
    reset_n = ($urandom_range(0, 399) != 0);
    stb = (m_own >= 0) && !m_xfer;
    if (!sd_ack) begin
      if (stb) begin
        if (h_cnt == 0) begin sd_ack = 1'b1; h_cnt = $urandom_range(0, 3); end
        else h_cnt--;
      end else h_cnt = $urandom_range(0, 13);
    end else begin
      if (h_cnt == 0) begin sd_ack = 1'b0; h_cnt = $urandom_range(0, 13); end
      else h_cnt--;
    end
  endtask

  initial begin
    reset_n = 1'b0; drv_reset = '0; drv_rd = '0; drv_wr = '0;
    drv_lba = '0; drv_blk_cnt = '0; drv_buff_din = '0;
    sd_ack = 1'b0; h_cnt = 0; e_ack = '0;
    model_reset();
    @(posedge clk_sys);
    @(negedge clk_sys);
    steps(2);
    reset_n = 1'b1;
    steps(1);

    // Drive 0 read, host acks for three cycles.
    drv_rd[0] = 1'b1; drv_lba[0] = 32'h165; drv_blk_cnt[0] = 6'd3;
    steps(3);
    sd_ack = 1'b1;
    steps(1);
    drv_rd[0] = 1'b0;
    steps(2);
    sd_ack = 1'b0;
    steps(3);

    // Drive 2 write, buffer data muxed only from the granted drive.
    drv_buff_din = {8'h00, 8'hA5, 8'h00, 8'h00};
    drv_wr[2] = 1'b1; drv_lba[2] = 32'hCAFE0002;
    steps(2);
    sd_ack = 1'b1;
    steps(2);
    drv_wr[2] = 1'b0;
    sd_ack = 1'b0;
    steps(3);

    // Drive 1 rd+wr: read wins; then reset during transfer.
    drv_rd[1] = 1'b1; drv_wr[1] = 1'b1;
    steps(2);
    sd_ack = 1'b1;
    steps(1);
    drv_reset[1] = 1'b1;
    steps(2);
    sd_ack = 1'b0; drv_rd[1] = 1'b0; drv_reset[1] = 1'b0;
    steps(3);

    // Drive 1 write withdrawn by drive reset while waiting.
    steps(2);
    drv_reset[1] = 1'b1;
    steps(2);
    drv_reset[1] = 1'b0; drv_wr[1] = 1'b0;
    steps(2);

    // Timeout on drive 0 with drive 1 pending.
    drv_rd[0] = 1'b1;
    steps(3);
    drv_wr[1] = 1'b1;
    steps(TMO + 2);
    sd_ack = 1'b1;
    steps(2);
    drv_wr[1] = 1'b0; sd_ack = 1'b0;
    steps(3);
    sd_ack = 1'b1;
    steps(2);
    reset_n = 1'b0;
    steps(2);
    reset_n = 1'b1; sd_ack = 1'b0; drv_rd = '0;
    steps(2);

    for (int c = 0; c < 4000; c++) begin
      rand_inputs();
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
